// File: rtl/fft_cbfp_pkg.sv
// Shared definitions for the block-floating-point normalizer after the
// stage-01 twiddle multiplier: default widths, exponent width and the
// per-sample helpers used both by the min tree and by the output scaler.
package fft_cbfp_pkg;

  localparam int CBFP_IN_W  = 13;
  localparam int CBFP_OUT_W = 10;
  localparam int CBFP_EXP_W = 4;

  // Bits discarded when going from the shifted IN_W sample to OUT_W.
  localparam int CBFP_DROP = CBFP_IN_W - CBFP_OUT_W;

  // Rounding offset and saturation bounds, held one bit wider than the input
  // so the offset addition cannot wrap.
  localparam logic signed [CBFP_IN_W:0] CBFP_HALF =
    (CBFP_IN_W+1)'(1 << (CBFP_DROP - 1));
  localparam logic signed [CBFP_IN_W:0] CBFP_SAT_HI =
    (CBFP_IN_W+1)'((1 << (CBFP_OUT_W - 1)) - 1);
  localparam logic signed [CBFP_IN_W:0] CBFP_SAT_LO =
    (CBFP_IN_W+1)'(-(1 << (CBFP_OUT_W - 1)));

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Number of bits directly below the MSB that repeat the sign bit.
  function automatic logic [CBFP_EXP_W-1:0] rs_count(
    input logic signed [CBFP_IN_W-1:0] x
  );
    logic [CBFP_EXP_W-1:0] n;
    logic                  run;
    n   = '0;
    run = 1'b1;
    for (int i = CBFP_IN_W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[CBFP_IN_W-1])) n = n + 1'b1;
      else run = 1'b0;
    end
    return n;
  endfunction

  // Normalize by the block shift, round half-up and clamp to OUT_W.
  // The shift never exceeds the sample's own redundant sign count, so the
  // left shift is lossless.
  function automatic logic signed [CBFP_OUT_W-1:0] round_sat(
    input logic signed [CBFP_IN_W-1:0] x,
    input logic        [CBFP_EXP_W-1:0] shift
  );
    logic signed [CBFP_IN_W-1:0] z;
    logic signed [CBFP_IN_W:0]   sum;
    logic signed [CBFP_IN_W:0]   y;
    logic signed [CBFP_OUT_W-1:0] r;
    z   = x <<< shift;
    sum = $signed({z[CBFP_IN_W-1], z}) + CBFP_HALF;
    y   = sum >>> CBFP_DROP;
    if (y > CBFP_SAT_HI)      r = CBFP_SAT_HI[CBFP_OUT_W-1:0];
    else if (y < CBFP_SAT_LO) r = CBFP_SAT_LO[CBFP_OUT_W-1:0];
    else                      r = y[CBFP_OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/cbfp_min_tree.sv
// Minimum redundant-sign-bit count over one beat (4 streams x LANES samples),
// with an optional output register.
module cbfp_min_tree
  import fft_cbfp_pkg::*;
#(
  parameter int LANES   = 16,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                         clk_i,
  input  logic signed [CBFP_IN_W-1:0]  sum_re_i  [0:LANES-1],
  input  logic signed [CBFP_IN_W-1:0]  sum_im_i  [0:LANES-1],
  input  logic signed [CBFP_IN_W-1:0]  diff_re_i [0:LANES-1],
  input  logic signed [CBFP_IN_W-1:0]  diff_im_i [0:LANES-1],
  output logic        [CBFP_EXP_W-1:0] min_o
);

  logic [CBFP_EXP_W-1:0] min_d;
  logic [CBFP_EXP_W-1:0] rs_d;

  // Linear min scan; synthesis rebalances it into a tree.
  always_comb begin
    min_d = CBFP_EXP_W'(CBFP_IN_W - 1);
    rs_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      rs_d = rs_count(sum_re_i[l]);
      if (rs_d < min_d) min_d = rs_d;
      rs_d = rs_count(sum_im_i[l]);
      if (rs_d < min_d) min_d = rs_d;
      rs_d = rs_count(diff_re_i[l]);
      if (rs_d < min_d) min_d = rs_d;
      rs_d = rs_count(diff_im_i[l]);
      if (rs_d < min_d) min_d = rs_d;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [CBFP_EXP_W-1:0] min_q;
      // Pure data register; its consumer is qualified by a reset valid bit.
      always_ff @(posedge clk_i) min_q <= min_d;
      assign min_o = min_q;
    end else begin : g_comb
      assign min_o = min_d;
    end
  endgenerate

endmodule

// File: rtl/cbfp_01.sv
// Block-floating-point normalizer: collects BLK_CYCLES beats per bank of a
// ping-pong buffer, derives one left shift per block from the smallest
// redundant sign count, then replays the block rounded/saturated to OUT_W.
// IN_W/OUT_W must match the package widths used by the helper functions.
module cbfp_01
  import fft_cbfp_pkg::*;
#(
  parameter int IN_W       = CBFP_IN_W,
  parameter int OUT_W      = CBFP_OUT_W,
  parameter int LANES      = 16,
  parameter int BLK_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic signed [IN_W-1:0]       in_sum_re   [0:LANES-1],
  input  logic signed [IN_W-1:0]       in_sum_im   [0:LANES-1],
  input  logic signed [IN_W-1:0]       in_diff_re  [0:LANES-1],
  input  logic signed [IN_W-1:0]       in_diff_im  [0:LANES-1],
  input  logic                         in_valid,
  output logic signed [OUT_W-1:0]      out_sum_re  [0:LANES-1],
  output logic signed [OUT_W-1:0]      out_sum_im  [0:LANES-1],
  output logic signed [OUT_W-1:0]      out_diff_re [0:LANES-1],
  output logic signed [OUT_W-1:0]      out_diff_im [0:LANES-1],
  output logic                         out_valid,
  output logic        [CBFP_EXP_W-1:0] out_exp,
  output logic                         out_last
);

  localparam int IDX_W = (BLK_CYCLES > 1) ? $clog2(BLK_CYCLES) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(BLK_CYCLES - 1);
  localparam logic [CBFP_EXP_W-1:0] EXP_MAX  = CBFP_EXP_W'(IN_W - 1);

  // Ping-pong sample storage, one array per stream.
  logic signed [IN_W-1:0] bank_sr_q [2][BLK_CYCLES][LANES];
  logic signed [IN_W-1:0] bank_si_q [2][BLK_CYCLES][LANES];
  logic signed [IN_W-1:0] bank_dr_q [2][BLK_CYCLES][LANES];
  logic signed [IN_W-1:0] bank_di_q [2][BLK_CYCLES][LANES];

  logic [IDX_W-1:0]      wr_idx_q;
  logic                  wr_bank_q;
  logic                  wr_last_d;

  // Stage p1: beat min arrives one cycle after the beat was written.
  logic                  vld_p1;
  logic                  last_p1;
  logic                  bank_p1;
  logic [CBFP_EXP_W-1:0] beat_min_p1;
  logic [CBFP_EXP_W-1:0] run_min_q;
  logic [CBFP_EXP_W-1:0] blk_min_d;
  logic [CBFP_EXP_W-1:0] exp_q [2];
  logic                  close_p1;

  drain_state_e          state_q;
  logic                  rd_bank_q;
  logic [IDX_W-1:0]      rd_idx_q;
  logic                  rd_last_d;

  assign wr_last_d = (wr_idx_q == IDX_LAST);
  assign close_p1  = vld_p1 && last_p1;
  assign blk_min_d = (beat_min_p1 < run_min_q) ? beat_min_p1 : run_min_q;
  assign rd_last_d = (rd_idx_q == IDX_LAST);

  cbfp_min_tree #(
    .LANES   (LANES),
    .REG_OUT (1'b1)
  ) u_min_tree (
    .clk_i     (clk),
    .sum_re_i  (in_sum_re),
    .sum_im_i  (in_sum_im),
    .diff_re_i (in_diff_re),
    .diff_im_i (in_diff_im),
    .min_o     (beat_min_p1)
  );

  // ---- stage p0: capture accepted beat into the active bank slot ----
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int l = 0; l < LANES; l++) begin
        bank_sr_q[wr_bank_q][wr_idx_q][l] <= in_sum_re[l];
        bank_si_q[wr_bank_q][wr_idx_q][l] <= in_sum_im[l];
        bank_dr_q[wr_bank_q][wr_idx_q][l] <= in_diff_re[l];
        bank_di_q[wr_bank_q][wr_idx_q][l] <= in_diff_im[l];
      end
    end
  end

  // Write pointer / bank toggle, and tagging of the beat for stage p1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      bank_p1   <= 1'b0;
    end else begin
      vld_p1  <= in_valid;
      last_p1 <= in_valid && wr_last_d;
      bank_p1 <= wr_bank_q;
      if (in_valid) begin
        if (wr_last_d) begin
          wr_idx_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_idx_q  <= wr_idx_q + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: running block minimum, latched as exponent on close ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_min_q <= EXP_MAX;
      exp_q[0]  <= '0;
      exp_q[1]  <= '0;
    end else if (vld_p1) begin
      if (last_p1) begin
        exp_q[bank_p1] <= blk_min_d;
        run_min_q      <= EXP_MAX;
      end else begin
        run_min_q      <= blk_min_d;
      end
    end
  end

  // ---- stage p2: drain FSM with registered, scaled outputs ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_exp   <= '0;
      for (int l = 0; l < LANES; l++) begin
        out_sum_re[l]  <= '0;
        out_sum_im[l]  <= '0;
        out_diff_re[l] <= '0;
        out_diff_im[l] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (close_p1) begin
            state_q   <= ST_DRAIN;
            rd_bank_q <= bank_p1;
            rd_idx_q  <= '0;
          end
        end
        ST_DRAIN: begin
          out_valid <= 1'b1;
          out_last  <= rd_last_d;
          out_exp   <= exp_q[rd_bank_q];
          for (int l = 0; l < LANES; l++) begin
            out_sum_re[l]  <= round_sat(bank_sr_q[rd_bank_q][rd_idx_q][l], exp_q[rd_bank_q]);
            out_sum_im[l]  <= round_sat(bank_si_q[rd_bank_q][rd_idx_q][l], exp_q[rd_bank_q]);
            out_diff_re[l] <= round_sat(bank_dr_q[rd_bank_q][rd_idx_q][l], exp_q[rd_bank_q]);
            out_diff_im[l] <= round_sat(bank_di_q[rd_bank_q][rd_idx_q][l], exp_q[rd_bank_q]);
          end
          if (rd_last_d) begin
            // A block closing on the final drain beat chains without a bubble.
            if (close_p1) begin
              rd_bank_q <= bank_p1;
              rd_idx_q  <= '0;
            end else begin
              state_q   <= ST_IDLE;
            end
          end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbfp_01.sv
// Bench for cbfp_01: directed and random blocks, scored against a block-level
// arithmetic model of the normalizer.
module tb_cbfp_01;

  localparam int IN_W  = 13;
  localparam int OUT_W = 10;
  localparam int LANES = 16;
  localparam int BLK   = 4;
  localparam int NS    = 4 * LANES;

  logic clk = 1'b0;
  logic rstn;
  logic signed [IN_W-1:0]  in_sum_re   [0:LANES-1];
  logic signed [IN_W-1:0]  in_sum_im   [0:LANES-1];
  logic signed [IN_W-1:0]  in_diff_re  [0:LANES-1];
  logic signed [IN_W-1:0]  in_diff_im  [0:LANES-1];
  logic                    in_valid;
  logic signed [OUT_W-1:0] out_sum_re  [0:LANES-1];
  logic signed [OUT_W-1:0] out_sum_im  [0:LANES-1];
  logic signed [OUT_W-1:0] out_diff_re [0:LANES-1];
  logic signed [OUT_W-1:0] out_diff_im [0:LANES-1];
  logic                    out_valid;
  logic [3:0]              out_exp;
  logic                    out_last;

  cbfp_01 dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_sum_re   (in_sum_re),
    .in_sum_im   (in_sum_im),
    .in_diff_re  (in_diff_re),
    .in_diff_im  (in_diff_im),
    .in_valid    (in_valid),
    .out_sum_re  (out_sum_re),
    .out_sum_im  (out_sum_im),
    .out_diff_re (out_diff_re),
    .out_diff_im (out_diff_im),
    .out_valid   (out_valid),
    .out_exp     (out_exp),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]           due;
    logic [3:0]            e;
    logic                  last;
    logic [NS-1:0][OUT_W-1:0] s;
  } exp_beat_t;

  exp_beat_t expq [$];
  int blk [BLK][NS];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Largest k such that x fits in IN_W-k signed bits.
  function automatic int rs_ref(input int x);
    for (int k = IN_W - 1; k >= 0; k--)
      if (x >= -(1 << (IN_W - 1 - k)) && x < (1 << (IN_W - 1 - k))) return k;
    return 0;
  endfunction

  function automatic int scale_ref(input int x, input int e);
    int y;
    y = (x * (1 << e) + 4) >>> 3;
    if (y > 511) y = 511;
    if (y < -512) y = -512;
    return y;
  endfunction

  task automatic push_block(input int t);
    exp_beat_t eb;
    int e;
    e = IN_W - 1;
    for (int b = 0; b < BLK; b++)
      for (int i = 0; i < NS; i++)
        if (rs_ref(blk[b][i]) < e) e = rs_ref(blk[b][i]);
    for (int b = 0; b < BLK; b++) begin
      eb.due  = 32'(t + 2 + b);
      eb.e    = 4'(e);
      eb.last = (b == BLK - 1);
      for (int i = 0; i < NS; i++) eb.s[i] = OUT_W'(scale_ref(blk[b][i], e));
      expq.push_back(eb);
    end
  endtask

  task automatic drive_beat(input int b);
    for (int l = 0; l < LANES; l++) begin
      in_sum_re[l]  = IN_W'(blk[b][l]);
      in_sum_im[l]  = IN_W'(blk[b][LANES + l]);
      in_diff_re[l] = IN_W'(blk[b][2*LANES + l]);
      in_diff_im[l] = IN_W'(blk[b][3*LANES + l]);
    end
  endtask

  task automatic fill_const(input int v);
    for (int b = 0; b < BLK; b++)
      for (int i = 0; i < NS; i++) blk[b][i] = v;
  endtask

  // Random samples in [-2^a, 2^a-1].
  task automatic fill_rand(input int a);
    for (int b = 0; b < BLK; b++)
      for (int i = 0; i < NS; i++)
        blk[b][i] = int'($urandom_range(0, (1 << (a + 1)) - 1)) - (1 << a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input bit gaps);
    for (int b = 0; b < BLK; b++) begin
      drive_beat(b);
      in_valid = 1'b1;
      tick();
      if (b == BLK - 1) push_block(cyc);
      if (gaps && b < BLK - 1) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_last"}, 32'(out_last), 0);
    chk({tag, " out_exp"}, 32'(out_exp), 0);
    for (int l = 0; l < LANES; l++) begin
      chk($sformatf("%s sum_re[%0d]", tag, l), 32'(out_sum_re[l]), 0);
      chk($sformatf("%s diff_im[%0d]", tag, l), 32'(out_diff_im[l]), 0);
    end
  endtask

  // Output scoreboard: every valid beat must match the head of the queue on
  // its due cycle; an expected beat that is not delivered on time is flagged.
  always @(negedge clk) begin
    exp_beat_t eb;
    if (rstn) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious out_valid", 32'(out_valid), 0);
        end else begin
          eb = expq.pop_front();
          chk("beat cycle", cyc, $signed(eb.due));
          chk("out_exp", 32'(out_exp), 32'(eb.e));
          chk("out_last", 32'(out_last), 32'(eb.last));
          for (int l = 0; l < LANES; l++) begin
            chk($sformatf("sum_re[%0d]", l),  out_sum_re[l],  $signed(eb.s[l]));
            chk($sformatf("sum_im[%0d]", l),  out_sum_im[l],  $signed(eb.s[LANES + l]));
            chk($sformatf("diff_re[%0d]", l), out_diff_re[l], $signed(eb.s[2*LANES + l]));
            chk($sformatf("diff_im[%0d]", l), out_diff_im[l], $signed(eb.s[3*LANES + l]));
          end
        end
      end else if (expq.size() > 0 && int'(expq[0].due) <= cyc) begin
        chk("out_valid on due beat", 32'(out_valid), 1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    int pos;
    rstn     = 1'b0;
    in_valid = 1'b0;
    fill_const(0);
    drive_beat(0);
    repeat (3) tick();
    check_outputs_zero("reset");
    rstn = 1'b1;
    tick();
    check_outputs_zero("post-release");

    // Single 100, rest zero: exponent 5, sample becomes 400.
    fill_const(0);
    pos = int'($urandom_range(0, NS - 1));
    blk[$urandom_range(0, BLK - 1)][pos] = 100;
    send_block(1'b0);
    repeat (8) tick();

    // Single -100 among small values: exponent 5, sample becomes -400.
    fill_rand(2);
    blk[2][$urandom_range(0, NS - 1)] = -100;
    send_block(1'b0);
    repeat (8) tick();

    // Full-scale extremes: exponent 0, saturation and round-half-up.
    fill_const(0);
    blk[0][3]  = 4095;
    blk[1][20] = -4096;
    blk[3][50] = 4;
    send_block(1'b0);
    repeat (8) tick();

    // All-zero block: maximum exponent, still four output beats.
    fill_const(0);
    send_block(1'b0);
    repeat (8) tick();

    // Three back-to-back blocks at full rate, independent magnitudes.
    for (int k = 0; k < 3; k++) begin
      fill_rand(int'($urandom_range(0, 12)));
      send_block(1'b0);
    end
    repeat (8) tick();

    // Blocks with a one-cycle gap between beats.
    for (int k = 0; k < 3; k++) begin
      fill_rand(int'($urandom_range(0, 12)));
      send_block(1'b1);
    end
    repeat (8) tick();

    // Reset during a drain with a partial block already written.
    fill_rand(11);
    send_block(1'b0);
    fill_rand(12);
    for (int b = 0; b < 2; b++) begin
      drive_beat(b);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    rstn = 1'b0;
    expq.delete();
    #1;
    check_outputs_zero("mid-drain reset");
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Fresh block after reset, small magnitude so stale data would show.
    fill_rand(4);
    send_block(1'b0);
    fill_rand(7);
    send_block(1'b1);

    for (int i = 0; i < 40 && expq.size() > 0; i++) tick();
    chk("pending beats after drain budget", expq.size(), 0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
